// File: rtl/player_motion.sv
// Per-frame sprite position engine: walking with wall clamps plus a jump/gravity FSM.
// All state advances only on the clk edge where a rising edge of frame_clk is seen.
module player_motion #(
  parameter logic [9:0] X_INIT   = 10'd100,
  parameter logic [9:0] X_MIN    = 10'd0,
  parameter logic [9:0] X_MAX    = 10'd624,
  parameter logic [9:0] Y_MIN    = 10'd65,
  parameter logic [9:0] Y_GROUND = 10'd400,
  parameter logic [3:0] STEP_X   = 4'd2,
  parameter logic [5:0] JUMP_V   = 6'd8,
  parameter logic [5:0] GRAVITY  = 6'd1,
  parameter logic [5:0] VMAX     = 6'd8
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
  output logic [9:0] PosX,
  output logic [9:0] PosY,
  output logic       facing_left,
  output logic       in_air
);

  typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

  localparam logic [5:0] VY_TAKEOFF = ~JUMP_V + 6'd1;

  state_t             state_q, state_d;
  logic [9:0]         pos_x_q, pos_x_d;
  logic [9:0]         pos_y_q, pos_y_d;
  logic signed [5:0]  vy_q, vy_d;
  logic               facing_q, facing_d;
  logic               in_air_q, in_air_d;
  logic               frame_q;
  logic               armed_q, armed_d;

  logic               tick;
  logic [10:0]        x_wide, x_inc;
  logic signed [11:0] y_next;
  logic signed [6:0]  vy_inc;

  assign tick   = frame_clk & ~frame_q;
  assign x_wide = {1'b0, pos_x_q};
  assign x_inc  = x_wide + {7'd0, STEP_X};
  assign y_next = $signed({2'b00, pos_y_q}) + $signed({{6{vy_q[5]}}, vy_q});
  assign vy_inc = $signed({vy_q[5], vy_q}) + $signed({1'b0, GRAVITY});

  always_comb begin
    state_d  = state_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    vy_d     = vy_q;
    facing_d = facing_q;
    armed_d  = armed_q;

    if (tick) begin
      if (key_left && !key_right) begin
        // Subtract only when the result stays at or above the wall, avoiding unsigned wrap.
        if (x_wide >= ({1'b0, X_MIN} + {7'd0, STEP_X}))
          pos_x_d = pos_x_q - {6'd0, STEP_X};
        else
          pos_x_d = X_MIN;
        facing_d = 1'b1;
      end else if (key_right && !key_left) begin
        if (x_inc > {1'b0, X_MAX})
          pos_x_d = X_MAX;
        else
          pos_x_d = x_inc[9:0];
        facing_d = 1'b0;
      end

      unique case (state_q)
        GROUND: begin
          if (key_jump && armed_q) begin
            state_d = RISE;
            vy_d    = VY_TAKEOFF;
            armed_d = 1'b0;
          end else begin
            vy_d = '0;
          end
        end
        RISE: begin
          if (y_next <= $signed({2'b00, Y_MIN})) begin
            pos_y_d = Y_MIN;
            vy_d    = '0;
            state_d = FALL;
          end else begin
            pos_y_d = y_next[9:0];
            vy_d    = vy_inc[5:0];
            if (!vy_inc[6])
              state_d = FALL;
          end
        end
        FALL: begin
          if (y_next >= $signed({2'b00, Y_GROUND})) begin
            pos_y_d = Y_GROUND;
            vy_d    = '0;
            state_d = GROUND;
          end else begin
            pos_y_d = y_next[9:0];
            if (vy_inc > $signed({1'b0, VMAX}))
              vy_d = VMAX;
            else
              vy_d = vy_inc[5:0];
          end
        end
        default: state_d = GROUND;
      endcase

      if (!key_jump)
        armed_d = 1'b1;
    end

    in_air_d = (state_d != GROUND);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q  <= GROUND;
      pos_x_q  <= X_INIT;
      pos_y_q  <= Y_GROUND;
      vy_q     <= '0;
      facing_q <= 1'b0;
      in_air_q <= 1'b0;
      frame_q  <= 1'b0;
      armed_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      vy_q     <= vy_d;
      facing_q <= facing_d;
      in_air_q <= in_air_d;
      frame_q  <= frame_clk;
      armed_q  <= armed_d;
    end
  end

  assign PosX        = pos_x_q;
  assign PosY        = pos_y_q;
  assign facing_left = facing_q;
  assign in_air      = in_air_q;

endmodule

// File: tb/tb_player_motion.sv
// Bench for player_motion: two instances (default and a low-ceiling/odd-start variant) share
// stimulus; a frame-level physics model fills per-instance expectation queues drained by a monitor.
module tb_player_motion;

  logic clk = 1'b0;
  logic Reset, frame_clk, key_left, key_right, key_jump;
  logic [9:0] px0, py0, px1, py1;
  logic fl0, air0, fl1, air1;

  always #10 clk = ~clk;

  player_motion dut0 (
    .clk(clk), .Reset(Reset), .frame_clk(frame_clk),
    .key_left(key_left), .key_right(key_right), .key_jump(key_jump),
    .PosX(px0), .PosY(py0), .facing_left(fl0), .in_air(air0)
  );

  player_motion #(.X_INIT(10'd623), .Y_MIN(10'd380)) dut1 (
    .clk(clk), .Reset(Reset), .frame_clk(frame_clk),
    .key_left(key_left), .key_right(key_right), .key_jump(key_jump),
    .PosX(px1), .PosY(py1), .facing_left(fl1), .in_air(air1)
  );

  typedef enum {M_GROUND, M_RISE, M_FALL} phase_t;
  typedef struct {
    int x; int y; int vy; phase_t ph; bit fl; bit armed; bit prev;
  } mdl_t;
  typedef struct {
    int due; int x; int y; bit fl; bit air;
  } exp_t;

  mdl_t m0, m1;
  exp_t q0[$], q1[$];
  exp_t e;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Sprite physics in whole pixels: one update per vsync rising edge.
  function automatic mdl_t step(input mdl_t m, input bit rst, fc, l, r, j,
                                input int x_init, input int y_min);
    mdl_t n = m;
    int yn;
    if (rst) begin
      n.x = x_init; n.y = 400; n.vy = 0; n.ph = M_GROUND;
      n.fl = 0; n.armed = 1; n.prev = 0;
      return n;
    end
    if (fc && !m.prev) begin
      if (l && !r) begin
        n.x = (m.x - 2 < 0) ? 0 : m.x - 2;
        n.fl = 1;
      end else if (r && !l) begin
        n.x = (m.x + 2 > 624) ? 624 : m.x + 2;
        n.fl = 0;
      end
      yn = m.y + m.vy;
      if (m.ph == M_GROUND) begin
        if (j && m.armed) begin
          n.ph = M_RISE; n.vy = -8; n.armed = 0;
        end else n.vy = 0;
      end else if (m.ph == M_RISE) begin
        if (yn <= y_min) begin
          n.y = y_min; n.vy = 0; n.ph = M_FALL;
        end else begin
          n.y = yn; n.vy = m.vy + 1;
          if (n.vy >= 0) n.ph = M_FALL;
        end
      end else begin
        if (yn >= 400) begin
          n.y = 400; n.vy = 0; n.ph = M_GROUND;
        end else begin
          n.y = yn; n.vy = (m.vy + 1 > 8) ? 8 : m.vy + 1;
        end
      end
      if (!j) n.armed = 1;
    end
    n.prev = fc;
    return n;
  endfunction

  task automatic apply(input bit rst, input bit fc, input bit l, input bit r, input bit j);
    Reset = rst; frame_clk = fc; key_left = l; key_right = r; key_jump = j;
    m0 = step(m0, rst, fc, l, r, j, 100, 65);
    m1 = step(m1, rst, fc, l, r, j, 623, 380);
    q0.push_back('{cyc + 1, m0.x, m0.y, m0.fl, m0.ph != M_GROUND});
    q1.push_back('{cyc + 1, m1.x, m1.y, m1.fl, m1.ph != M_GROUND});
    @(negedge clk);
  endtask

  task automatic frame(input int hi, input int lo, input bit l, input bit r, input bit j);
    repeat (hi) apply(0, 1, l, r, j);
    repeat (lo) apply(0, 0, l, r, j);
  endtask

  task automatic check(input string name, input exp_t x, input logic [9:0] px,
                       input logic [9:0] py, input logic fl, input logic air);
    n_cmp++;
    if (px !== 10'(x.x) || py !== 10'(x.y) || fl !== x.fl || air !== x.air) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got x=%0d y=%0d fl=%b air=%b expected x=%0d y=%0d fl=%b air=%b",
               name, cyc, px, py, fl, air, x.x, x.y, x.fl, x.air);
    end
  endtask

  always @(negedge clk) begin
    while (q0.size() > 0 && q0[0].due <= cyc) begin
      e = q0.pop_front();
      check("dut0", e, px0, py0, fl0, air0);
    end
    while (q1.size() > 0 && q1[0].due <= cyc) begin
      e = q1.pop_front();
      check("dut1", e, px1, py1, fl1, air1);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1; frame_clk = 0; key_left = 0; key_right = 0; key_jump = 0;
    @(negedge clk);
    apply(1, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0);
    repeat (10) frame(1, 1, 0, 0, 0);

    frame(1, 1, 0, 1, 0);
    frame(1000, 1, 0, 1, 0);
    frame(3, 2, 0, 1, 0);
    frame(2, 2, 1, 0, 0);
    frame(1, 1, 1, 1, 0);

    frame(1, 1, 0, 0, 1);
    repeat (20) frame(1, 1, 0, 0, 0);

    repeat (40) frame(1, 1, 0, 0, 1);
    frame(1, 1, 0, 0, 0);
    repeat (5) frame(1, 1, 0, 0, 1);
    repeat (20) frame(1, 1, 0, 0, 0);

    frame(1, 1, 0, 0, 1);
    repeat (5) frame(1, 1, 0, 0, 0);
    apply(1, 1, 0, 0, 0);
    apply(0, 1, 0, 0, 0);
    repeat (5) frame(1, 1, 0, 0, 0);

    repeat (320) frame(1, 1, 1, 0, 0);
    repeat (320) frame(1, 1, 0, 1, 0);
    repeat (5) frame(1, 1, 1, 1, 0);

    repeat (500) begin
      if ($urandom_range(0, 99) == 0) apply(1, $urandom_range(0, 1) == 1, 0, 0, 0);
      frame($urandom_range(1, 4), $urandom_range(1, 3),
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
    end

    repeat (3) @(negedge clk);
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got q0=%0d q1=%0d pending expected 0", q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
